// File: rtl/int_service_ctrl.sv
// Interrupt acceptance and hardware-LCALL sequencer: picks a request at an instruction
// boundary by IP level, pushes the return PC, redirects fetch and tracks in-service levels.
module int_service_ctrl #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  int_req,
  input  logic [4:0]  ip,
  input  logic        instr_end,
  input  logic        is_reti,
  input  logic        ie_ip_wr,
  input  logic [15:0] pc_cur,
  output logic        push_req,
  output logic [7:0]  push_data,
  input  logic        push_ack,
  output logic        int_take,
  output logic [15:0] vec_addr,
  output logic [4:0]  int_ack,
  output logic        busy,
  output logic [1:0]  in_service
);

  typedef enum logic [1:0] {StIdle, StPushLo, StPushHi, StJump} state_e;

  state_e      state;
  logic [2:0]  idx;
  logic        lvl;
  logic [15:0] pc;
  logic        blk;

  logic [4:0]  hi;
  logic [4:0]  lo;
  logic        cand_lvl;
  logic [2:0]  cand_idx;
  logic        eligible;
  logic [15:0] vec_next;

  function automatic logic [2:0] lowest(input logic [4:0] v);
    lowest = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  always_comb begin
    hi       = int_req & ip;
    lo       = int_req & ~ip;
    cand_lvl = |hi;
    cand_idx = lowest(cand_lvl ? hi : lo);
    // High nests over low; low only starts when nothing is in service.
    eligible = (state == StIdle) && instr_end && !blk && !is_reti && !ie_ip_wr &&
               (cand_lvl ? !in_service[1] : ((|lo) && (in_service == 2'b00)));
    vec_next = VEC_BASE + (16'(idx) * VEC_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      idx        <= 3'd0;
      lvl        <= 1'b0;
      pc         <= 16'h0000;
      blk        <= 1'b0;
      push_req   <= 1'b0;
      push_data  <= 8'h00;
      int_take   <= 1'b0;
      vec_addr   <= 16'h0000;
      int_ack    <= 5'b00000;
      busy       <= 1'b0;
      in_service <= 2'b00;
    end else begin
      int_take <= 1'b0;
      int_ack  <= 5'b00000;
      vec_addr <= 16'h0000;
      unique case (state)
        StIdle: begin
          if (instr_end) begin
            // Guarantees one more instruction after RETI or an IE/IP write.
            blk <= is_reti | ie_ip_wr;
            if (is_reti) begin
              if (in_service[1]) in_service[1] <= 1'b0;
              else               in_service[0] <= 1'b0;
            end
          end
          if (eligible) begin
            idx       <= cand_idx;
            lvl       <= cand_lvl;
            pc        <= pc_cur;
            push_req  <= 1'b1;
            push_data <= pc_cur[7:0];
            busy      <= 1'b1;
            state     <= StPushLo;
          end
        end
        StPushLo: begin
          if (push_ack) begin
            push_data <= pc[15:8];
            state     <= StPushHi;
          end
        end
        StPushHi: begin
          if (push_ack) begin
            push_req        <= 1'b0;
            push_data       <= 8'h00;
            int_take        <= 1'b1;
            int_ack         <= 5'b00001 << idx;
            vec_addr        <= vec_next;
            in_service[lvl] <= 1'b1;
            state           <= StJump;
          end
        end
        StJump: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
